// File: rtl/tconv_pkg.sv
// Shared state encoding and default sizing for the transpose-convolution bank loaders.
package tconv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  localparam int DATA_WIDTH_DEF = 20;
  localparam int NUM_BANKS_DEF  = 16;
  localparam int ADDR_WIDTH_DEF = 9;
  localparam int BANK_SEL_W     = $clog2(NUM_BANKS_DEF);

  // Bank-select width for an arbitrary power-of-two bank count (never zero bits).
  function automatic int sel_width(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/mm2s_bank_loader_if.sv
// AXI-Stream beat channel from the MM2S FIFO into the bank loader.
interface mm2s_bank_loader_if import tconv_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/mm2s_bank_loader_bank_addr_gen.sv
// Bank/row counter pair: one registered one-hot write strobe and address per accepted beat.
// Latency one cycle from inc to we/addr; no backpressure of its own (follows inc).
module bank_addr_gen import tconv_pkg::*; #(
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic                  inc,
  output logic [NUM_BANKS-1:0]  we,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int SEL_W = sel_width(NUM_BANKS);

  logic [SEL_W-1:0]      bank_q;
  logic [ADDR_WIDTH-1:0] row_q;
  logic [ADDR_WIDTH-1:0] base_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= '0;
      row_q  <= '0;
      base_q <= '0;
      we     <= '0;
      addr   <= '0;
    end else begin
      we <= '0;
      if (load) begin
        bank_q <= '0;
        row_q  <= '0;
        base_q <= base;
      end else if (inc) begin
        we     <= NUM_BANKS'(1) << bank_q;
        // Sum is kept at ADDR_WIDTH so rows past the top of the bank wrap to 0.
        addr   <= base_q + row_q;
        bank_q <= bank_q + 1'b1;
        if (&bank_q) begin
          row_q <= row_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mm2s_bank_loader.sv
// Scatters MM2S words round-robin into NUM_BANKS BRAMs; writes land one cycle after acceptance.
// tready is high only in LOAD; optional running checksum under MM2S_BANK_LOADER_CHECKSUM_EN.
module mm2s_bank_loader import tconv_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  mm2s_bank_loader_if.slave     s_axis,
  output logic [NUM_BANKS-1:0]  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err_early_last,
  output logic                  err_missing_last
`ifdef MM2S_BANK_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  loader_state_t state, next_state;

  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] idx_q;
  logic                 arm;
  logic                 accept;
  logic                 last_word;
  logic                 end_beat;

  assign arm       = (state == IDLE) && start;
  assign accept    = s_axis.tvalid && s_axis.tready;
  assign last_word = (idx_q == len_q - LEN_WIDTH'(1));
  assign end_beat  = accept && (last_word || s_axis.tlast);

  assign s_axis.tready = (state == LOAD);
  assign busy          = (state == LOAD);
  assign done          = (state == DONE);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (cfg_len != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (end_beat) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      len_q            <= '0;
      idx_q            <= '0;
      err_early_last   <= 1'b0;
      err_missing_last <= 1'b0;
      bram_wdata       <= '0;
    end else begin
      if (arm) begin
        len_q            <= cfg_len;
        idx_q            <= '0;
        err_early_last   <= 1'b0;
        err_missing_last <= 1'b0;
      end else if (accept) begin
        idx_q      <= idx_q + LEN_WIDTH'(1);
        bram_wdata <= s_axis.tdata;
        if (s_axis.tlast && !last_word) begin
          err_early_last <= 1'b1;
        end
        if (last_word && !s_axis.tlast) begin
          err_missing_last <= 1'b1;
        end
      end
    end
  end

`ifdef MM2S_BANK_LOADER_CHECKSUM_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      checksum <= '0;
    end else if (arm) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + 32'(s_axis.tdata);
    end
  end
`endif

  bank_addr_gen #(
    .NUM_BANKS  (NUM_BANKS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk  (aclk),
    .rst  (areset),
    .load (arm),
    .base (cfg_base_addr),
    .inc  (accept),
    .we   (bram_we),
    .addr (bram_addr)
  );

endmodule

// File: tb/tb_mm2s_bank_loader.sv
// Directed bench for mm2s_bank_loader: shadow BRAM image filled from the write port, checked per word.
module tb_mm2s_bank_loader;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [8:0]  cfg_base_addr = '0;
  logic [15:0] bram_we;
  logic [8:0]  bram_addr;
  logic [19:0] bram_wdata;
  logic        busy, done, err_early_last, err_missing_last;
`ifdef MM2S_BANK_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  mm2s_bank_loader_if #(.DATA_WIDTH(20)) s_axis ();

  always #5 aclk = ~aclk;

  mm2s_bank_loader dut (
    .aclk             (aclk),
    .areset           (areset),
    .start            (start),
    .cfg_len          (cfg_len),
    .cfg_base_addr    (cfg_base_addr),
    .s_axis           (s_axis),
    .bram_we          (bram_we),
    .bram_addr        (bram_addr),
    .bram_wdata       (bram_wdata),
    .busy             (busy),
    .done             (done),
    .err_early_last   (err_early_last),
    .err_missing_last (err_missing_last)
`ifdef MM2S_BANK_LOADER_CHECKSUM_EN
    ,
    .checksum         (checksum)
`endif
  );

  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] done_we = '0;
  logic        acc_prev = 1'b0;
  logic [19:0] mem [16][512];

  // Shadow memory plus write-timing check: a strobe appears exactly one cycle after an accepted beat.
  always @(negedge aclk) begin
    if (areset) begin
      acc_prev = 1'b0;
    end else begin
      total++;
      assert ((bram_we != '0) === acc_prev) else begin
        bad++;
        $error("FAIL wr_timing observed_we=%0h expected_write=%0b", bram_we, acc_prev);
      end
      if (bram_we != '0) begin
        total++;
        assert ($onehot(bram_we)) else begin
          bad++;
          $error("FAIL we_onehot observed=%0h expected=onehot", bram_we);
        end
        wr_cnt++;
        for (int b = 0; b < 16; b++) begin
          if (bram_we[b]) mem[b][bram_addr] = bram_wdata;
        end
      end
      if (done) begin
        done_cnt++;
        done_we = bram_we;
      end
      acc_prev = s_axis.tvalid && s_axis.tready;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"}, 32'(bram_we), 32'd0);
    check({tag, "_addr"}, 32'(bram_addr), 32'd0);
    check({tag, "_wdata"}, 32'(bram_wdata), 32'd0);
    check({tag, "_tready"}, 32'(s_axis.tready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_eearly"}, 32'(err_early_last), 32'd0);
    check({tag, "_emiss"}, 32'(err_missing_last), 32'd0);
`ifdef MM2S_BANK_LOADER_CHECKSUM_EN
    check({tag, "_csum"}, checksum, 32'd0);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int b = 0; b < 16; b++)
      for (int a = 0; a < 512; a++) mem[b][a] = 20'hFFFFF;
  endtask

  task automatic arm(input logic [15:0] len, input logic [8:0] base);
    start = 1'b1;
    cfg_len = len;
    cfg_base_addr = base;
    @(posedge aclk);
    #1;
    start = 1'b0;
  endtask

  // Offer nbeats beats (data d0, d0+1, ...); stops once the loader leaves LOAD.
  task automatic send(input string tag, input int nbeats, input int last_at,
                      input logic [19:0] d0, input bit gaps, output int consumed);
    int cyc;
    bit acc;
    bit ph;
    cyc = 0;
    ph = 1'b1;
    consumed = 0;
    while (consumed < nbeats && cyc < 200) begin
      s_axis.tvalid = gaps ? ph : 1'b1;
      s_axis.tdata = d0 + 20'(consumed);
      s_axis.tlast = (consumed + 1 == last_at);
      @(negedge aclk);
      if (!busy) break;
      acc = s_axis.tvalid && s_axis.tready;
      @(posedge aclk);
      #1;
      if (acc) consumed++;
      ph = ~ph;
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < 200), 32'd1);
    if (nbeats > consumed) check({tag, "_tready_after"}, 32'(s_axis.tready), 32'd0);
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
  endtask

  task automatic check_words(input string tag, input int n, input int base, input logic [19:0] d0);
    for (int j = 0; j < n; j++) begin
      check($sformatf("%s_w%0d", tag, j), 32'(mem[j % 16][(base + j / 16) % 512]), 32'(d0 + 20'(j)));
    end
  endtask

  initial begin
    int n, w0, d0c;
    s_axis.tvalid = 1'b0;
    s_axis.tdata = '0;
    s_axis.tlast = 1'b0;
    clear_mem();
    idle(3);
    check_zero("rst");
    areset = 1'b0;
    idle(1);
    check_zero("post_rst");

    // Basic 32-word load, base 0
    w0 = wr_cnt; d0c = done_cnt;
    arm(16'd32, 9'd0);
    check("basic_busy", 32'(busy), 32'd1);
    send("basic", 32, 32, 20'd1, 1'b0, n);
    idle(3);
    check("basic_n", 32'(n), 32'd32);
    check("basic_wr", 32'(wr_cnt - w0), 32'd32);
    check("basic_done", 32'(done_cnt - d0c), 32'd1);
    check("basic_done_we", 32'(done_we), 32'h8000);
    check("basic_eearly", 32'(err_early_last), 32'd0);
    check("basic_emiss", 32'(err_missing_last), 32'd0);
    check("basic_b0a0", 32'(mem[0][0]), 32'd1);
    check("basic_b15a1", 32'(mem[15][1]), 32'd32);
    check_words("basic", 32, 0, 20'd1);
`ifdef MM2S_BANK_LOADER_CHECKSUM_EN
    check("basic_csum", checksum, 32'd528);
`endif

    // tvalid toggling 1-0-1
    clear_mem();
    w0 = wr_cnt; d0c = done_cnt;
    arm(16'd20, 9'd5);
    send("gaps", 20, 20, 20'd101, 1'b1, n);
    idle(3);
    check("gaps_n", 32'(n), 32'd20);
    check("gaps_wr", 32'(wr_cnt - w0), 32'd20);
    check("gaps_done", 32'(done_cnt - d0c), 32'd1);
    check("gaps_done_we", 32'(done_we), 32'h0008);
    check("gaps_emiss", 32'(err_missing_last), 32'd0);
    check_words("gaps", 20, 5, 20'd101);

    // tlast on beat 6 of 10
    clear_mem();
    w0 = wr_cnt; d0c = done_cnt;
    arm(16'd10, 9'd0);
    send("early", 10, 6, 20'h300, 1'b0, n);
    idle(3);
    check("early_n", 32'(n), 32'd6);
    check("early_wr", 32'(wr_cnt - w0), 32'd6);
    check("early_done", 32'(done_cnt - d0c), 32'd1);
    check("early_eearly", 32'(err_early_last), 32'd1);
    check("early_emiss", 32'(err_missing_last), 32'd0);
    check("early_b6", 32'(mem[6][0]), 32'hFFFFF);
    check_words("early", 6, 0, 20'h300);

    // tlast only on beat 9 of an 8-word load
    clear_mem();
    w0 = wr_cnt; d0c = done_cnt;
    arm(16'd8, 9'd40);
    send("miss", 9, 9, 20'h400, 1'b0, n);
    idle(3);
    check("miss_n", 32'(n), 32'd8);
    check("miss_wr", 32'(wr_cnt - w0), 32'd8);
    check("miss_done", 32'(done_cnt - d0c), 32'd1);
    check("miss_emiss", 32'(err_missing_last), 32'd1);
    check("miss_eearly", 32'(err_early_last), 32'd0);
    check_words("miss", 8, 40, 20'h400);

    // Base 511: word 16 wraps to bank 0, address 0
    clear_mem();
    w0 = wr_cnt;
    arm(16'd17, 9'd511);
    send("wrap", 17, 17, 20'h500, 1'b0, n);
    idle(3);
    check("wrap_wr", 32'(wr_cnt - w0), 32'd17);
    check("wrap_b0a511", 32'(mem[0][511]), 32'h500);
    check("wrap_b0a0", 32'(mem[0][0]), 32'h510);
    check("wrap_b15a511", 32'(mem[15][511]), 32'h50F);
    check("wrap_emiss", 32'(err_missing_last), 32'd0);

    // Zero length goes straight to DONE
    w0 = wr_cnt; d0c = done_cnt;
    arm(16'd0, 9'd3);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_tready", 32'(s_axis.tready), 32'd0);
`ifdef MM2S_BANK_LOADER_CHECKSUM_EN
    check("zero_csum", checksum, 32'd0);
`endif
    idle(1);
    check("zero_done_off", 32'(done), 32'd0);
    idle(2);
    check("zero_wr", 32'(wr_cnt - w0), 32'd0);
    check("zero_done_cnt", 32'(done_cnt - d0c), 32'd1);

    // Reset after 5 beats of a 32-beat load
    clear_mem();
    d0c = done_cnt;
    arm(16'd32, 9'd0);
    send("mid", 5, 0, 20'h600, 1'b0, n);
    areset = 1'b1;
    #1;
    check_zero("mid_rst");
    w0 = wr_cnt;
    idle(3);
    areset = 1'b0;
    idle(3);
    check("mid_wr_after", 32'(wr_cnt - w0), 32'd0);
    check("mid_done", 32'(done_cnt - d0c), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);

    clear_mem();
    w0 = wr_cnt; d0c = done_cnt;
    arm(16'd4, 9'd100);
    send("post", 4, 4, 20'h700, 1'b0, n);
    idle(3);
    check("post_wr", 32'(wr_cnt - w0), 32'd4);
    check("post_done", 32'(done_cnt - d0c), 32'd1);
    check("post_done_we", 32'(done_we), 32'h0008);
    check("post_eearly", 32'(err_early_last), 32'd0);
    check("post_emiss", 32'(err_missing_last), 32'd0);
    check_words("post", 4, 100, 20'h700);
`ifdef MM2S_BANK_LOADER_CHECKSUM_EN
    check("post_csum", checksum, 32'h1C06);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
